// File: rtl/subservient_dbg_loader_if.sv
// Byte-stream, control/status and debug Wishbone signals of the firmware loader.
// The master modport is the loader; the slave modport is the front end / SoC side.
interface subservient_dbg_loader_if #(
    parameter int DW    = 32,
    parameter int AW    = 32,
    parameter int LEN_W = 16
);
    localparam int NB = DW / 8;

    logic             i_start;
    logic [AW-1:0]    i_base_adr;
    logic [LEN_W-1:0] i_len;
    logic [7:0]       i_byte;
    logic             i_byte_valid;
    logic             o_byte_ready;
    logic             o_debug_mode;
    logic [AW-1:0]    o_wb_adr;
    logic [DW-1:0]    o_wb_dat;
    logic [NB-1:0]    o_wb_sel;
    logic             o_wb_we;
    logic             o_wb_stb;
    logic [DW-1:0]    i_wb_rdt;
    logic             i_wb_ack;
    logic             o_busy;
    logic             o_done;
    logic             o_err;

    modport master (
        input  i_start, i_base_adr, i_len, i_byte, i_byte_valid, i_wb_rdt, i_wb_ack,
        output o_byte_ready, o_debug_mode, o_wb_adr, o_wb_dat, o_wb_sel, o_wb_we,
               o_wb_stb, o_busy, o_done, o_err
    );

    modport slave (
        output i_start, i_base_adr, i_len, i_byte, i_byte_valid, i_wb_rdt, i_wb_ack,
        input  o_byte_ready, o_debug_mode, o_wb_adr, o_wb_dat, o_wb_sel, o_wb_we,
               o_wb_stb, o_busy, o_done, o_err
    );
endinterface

// File: rtl/subservient_dbg_loader.sv
// Firmware loader: packs a byte stream little-endian into DW-bit words and writes them over
// the debug Wishbone port. Optional readback verify: define SUBSERVIENT_DBG_LOADER_READBACK_EN.
module subservient_dbg_loader #(
    parameter int DW      = 32,
    parameter int AW      = 32,
    parameter int LEN_W   = 16,
    parameter int SETTLE  = 10,
    parameter int TIMEOUT = 255
) (
    input logic                     i_clk,
    input logic                     i_rst,
    subservient_dbg_loader_if.master bus
);
    localparam int NB       = DW / 8;
    localparam int KW       = (NB > 1) ? $clog2(NB) : 1;
    localparam int SW       = (SETTLE > 0) ? $clog2(SETTLE + 1) : 1;
    localparam int TW       = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam int TMO_LAST = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;
    localparam bit TMO_EN   = (TIMEOUT != 0);

`ifdef SUBSERVIENT_DBG_LOADER_READBACK_EN
    typedef enum logic [2:0] {ST_IDLE, ST_PRE, ST_COLLECT, ST_WRITE, ST_VERIFY, ST_POST} state_t;
`else
    typedef enum logic [2:0] {ST_IDLE, ST_PRE, ST_COLLECT, ST_WRITE, ST_POST} state_t;
`endif

    state_t           state_reg;
    logic [SW-1:0]    settle_reg;
    logic [TW-1:0]    tmo_reg;
    logic [LEN_W-1:0] left_reg;
    logic [KW-1:0]    lane_reg;
    logic [DW-1:0]    word_reg;
    logic [AW-1:0]    adr_reg;
    logic [DW-1:0]    dat_reg;
    logic [NB-1:0]    sel_reg;
    logic             stb_reg;
    logic             we_reg;
    logic             ready_reg;
    logic             debug_reg;
    logic             busy_reg;
    logic             done_reg;
    logic             err_reg;

    logic             accept;
    logic             last_of_word;
    logic             last_of_len;
    logic             tmo_hit;
    logic [DW-1:0]    word_next;

    assign accept       = ready_reg & bus.i_byte_valid;
    assign last_of_word = (lane_reg == KW'(NB - 1));
    assign last_of_len  = (left_reg == LEN_W'(1));
    assign tmo_hit      = TMO_EN && (tmo_reg == TW'(TMO_LAST));

    // Byte k of a word lands in lane k; untouched lanes keep their (initially zero) value
    for (genvar gi = 0; gi < NB; gi++) begin : g_lane
        assign word_next[8*gi +: 8] = (accept && (lane_reg == KW'(gi))) ? bus.i_byte
                                                                         : word_reg[8*gi +: 8];
    end

`ifndef SUBSERVIENT_DBG_LOADER_READBACK_EN
    logic unused_rdt;
    assign unused_rdt = ^bus.i_wb_rdt;
`endif

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_reg  <= ST_IDLE;
            settle_reg <= '0;
            tmo_reg    <= '0;
            left_reg   <= '0;
            lane_reg   <= '0;
            word_reg   <= '0;
            adr_reg    <= '0;
            dat_reg    <= '0;
            sel_reg    <= '0;
            stb_reg    <= 1'b0;
            we_reg     <= 1'b0;
            ready_reg  <= 1'b0;
            debug_reg  <= 1'b0;
            busy_reg   <= 1'b0;
            done_reg   <= 1'b0;
            err_reg    <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (bus.i_start) begin
                        adr_reg    <= bus.i_base_adr;
                        left_reg   <= bus.i_len;
                        err_reg    <= 1'b0;
                        busy_reg   <= 1'b1;
                        debug_reg  <= 1'b1;
                        settle_reg <= '0;
                        state_reg  <= ST_PRE;
                    end
                end
                ST_PRE: begin
                    if (settle_reg == SW'(SETTLE - 1)) begin
                        settle_reg <= '0;
                        if (left_reg == '0) begin
                            state_reg <= ST_POST;
                        end else begin
                            state_reg <= ST_COLLECT;
                            ready_reg <= 1'b1;
                            lane_reg  <= '0;
                            word_reg  <= '0;
                        end
                    end else begin
                        settle_reg <= settle_reg + SW'(1);
                    end
                end
                ST_COLLECT: begin
                    if (accept) begin
                        word_reg <= word_next;
                        left_reg <= left_reg - LEN_W'(1);
                        lane_reg <= lane_reg + KW'(1);
                        if (last_of_word || last_of_len) begin
                            ready_reg <= 1'b0;
                            dat_reg   <= word_next;
                            stb_reg   <= 1'b1;
                            we_reg    <= 1'b1;
                            sel_reg   <= '1;
                            tmo_reg   <= '0;
                            state_reg <= ST_WRITE;
                        end
                    end
                end
                ST_WRITE: begin
                    // Ack takes priority, so an ack in the last allowed cycle still completes
                    if (bus.i_wb_ack) begin
                        stb_reg <= 1'b0;
                        we_reg  <= 1'b0;
                        sel_reg <= '0;
`ifdef SUBSERVIENT_DBG_LOADER_READBACK_EN
                        state_reg <= ST_VERIFY;
`else
                        if (left_reg != '0) begin
                            state_reg <= ST_COLLECT;
                            ready_reg <= 1'b1;
                            lane_reg  <= '0;
                            word_reg  <= '0;
                            adr_reg   <= adr_reg + AW'(NB);
                        end else begin
                            state_reg  <= ST_POST;
                            settle_reg <= '0;
                        end
`endif
                    end else if (tmo_hit) begin
                        stb_reg    <= 1'b0;
                        we_reg     <= 1'b0;
                        sel_reg    <= '0;
                        err_reg    <= 1'b1;
                        settle_reg <= '0;
                        state_reg  <= ST_POST;
                    end else begin
                        tmo_reg <= tmo_reg + TW'(1);
                    end
                end
`ifdef SUBSERVIENT_DBG_LOADER_READBACK_EN
                ST_VERIFY: begin
                    // One idle bus cycle separates the write from its readback
                    if (!stb_reg) begin
                        stb_reg <= 1'b1;
                        we_reg  <= 1'b0;
                        sel_reg <= '1;
                        tmo_reg <= '0;
                    end else if (bus.i_wb_ack) begin
                        stb_reg <= 1'b0;
                        sel_reg <= '0;
                        if (bus.i_wb_rdt != dat_reg) begin
                            err_reg <= 1'b1;
                        end
                        if (left_reg != '0) begin
                            state_reg <= ST_COLLECT;
                            ready_reg <= 1'b1;
                            lane_reg  <= '0;
                            word_reg  <= '0;
                            adr_reg   <= adr_reg + AW'(NB);
                        end else begin
                            state_reg  <= ST_POST;
                            settle_reg <= '0;
                        end
                    end else if (tmo_hit) begin
                        stb_reg    <= 1'b0;
                        sel_reg    <= '0;
                        err_reg    <= 1'b1;
                        settle_reg <= '0;
                        state_reg  <= ST_POST;
                    end else begin
                        tmo_reg <= tmo_reg + TW'(1);
                    end
                end
`endif
                ST_POST: begin
                    // Runs SETTLE+1 cycles so debug mode spans 2*SETTLE+1 cycles on an empty load
                    if (settle_reg == SW'(SETTLE)) begin
                        debug_reg <= 1'b0;
                        busy_reg  <= 1'b0;
                        done_reg  <= 1'b1;
                        state_reg <= ST_IDLE;
                    end else begin
                        settle_reg <= settle_reg + SW'(1);
                    end
                end
                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.o_byte_ready = ready_reg;
    assign bus.o_debug_mode = debug_reg;
    assign bus.o_wb_adr     = adr_reg;
    assign bus.o_wb_dat     = dat_reg;
    assign bus.o_wb_sel     = sel_reg;
    assign bus.o_wb_we      = we_reg;
    assign bus.o_wb_stb     = stb_reg;
    assign bus.o_busy       = busy_reg;
    assign bus.o_done       = done_reg;
    assign bus.o_err        = err_reg;
endmodule

// File: tb/tb_subservient_dbg_loader.sv
// Directed bench for subservient_dbg_loader: byte source, Wishbone memory with
// programmable ack latency, and a linear sequence of load scenarios.
module tb_subservient_dbg_loader;
    localparam int DW = 32, AW = 32, LEN_W = 16, SETTLE = 3, TIMEOUT = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    subservient_dbg_loader_if #(.DW(DW), .AW(AW), .LEN_W(LEN_W)) bus ();

    subservient_dbg_loader #(
        .DW(DW), .AW(AW), .LEN_W(LEN_W), .SETTLE(SETTLE), .TIMEOUT(TIMEOUT)
    ) dut (
        .i_clk(clk),
        .i_rst(rst),
        .bus  (bus)
    );

    // Controls written only by the main sequence
    bit          ack_en      = 1'b1;
    int          ack_lat     = 0;
    bit          corrupt_en  = 1'b0;
    logic [31:0] corrupt_adr = 32'h0;
    logic [7:0]  src_mem[32];
    int          src_n   = 0;
    int          src_gen = 0;

    // Byte source: holds valid while bytes remain, advances after each accepted byte
    int src_idx  = 0;
    int last_gen = 0;
    bit pend     = 1'b0;
    int acc_cnt  = 0;
    always @(negedge clk) begin
        if (src_gen != last_gen) begin
            last_gen = src_gen;
            src_idx  = 0;
            pend     = 1'b0;
        end else if (pend) begin
            src_idx++;
            acc_cnt++;
        end
        bus.i_byte_valid = (src_idx < src_n);
        bus.i_byte       = (src_idx < src_n) ? src_mem[src_idx] : 8'h00;
        pend = bus.i_byte_valid && bus.o_byte_ready && !rst;
    end

    // Wishbone memory: acks after ack_lat waiting cycles, logs every write
    logic [31:0] mem[logic [31:0]];
    logic [31:0] wr_adr[64];
    logic [31:0] wr_dat[64];
    int          wr_n     = 0;
    int          wait_cnt = 0;
    int          stb_cnt  = 0;
    always @(negedge clk) begin
        bus.i_wb_ack = 1'b0;
        if (bus.o_wb_stb) begin
            stb_cnt++;
            if (ack_en && wait_cnt == ack_lat) begin
                bus.i_wb_ack = 1'b1;
                wait_cnt = 0;
                if (bus.o_wb_we) begin
                    mem[bus.o_wb_adr] = bus.o_wb_dat;
                    if (wr_n < 64) begin
                        wr_adr[wr_n] = bus.o_wb_adr;
                        wr_dat[wr_n] = bus.o_wb_dat;
                    end
                    wr_n++;
                end else begin
                    bus.i_wb_rdt = (mem.exists(bus.o_wb_adr) ? mem[bus.o_wb_adr] : 32'h0)
                                 ^ ((corrupt_en && bus.o_wb_adr == corrupt_adr) ? 32'h1 : 32'h0);
                end
            end else begin
                wait_cnt++;
            end
        end else begin
            wait_cnt = 0;
        end
    end

    int done_cnt  = 0;
    int debug_cnt = 0;
    always @(negedge clk) begin
        if (bus.o_done) done_cnt++;
        if (bus.o_debug_mode) debug_cnt++;
    end

    task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", name, obs, exp);
        end
    endtask

    task automatic set_seq(input logic [7:0] first, input int n);
        for (int i = 0; i < n; i++) src_mem[i] = first + 8'(i);
        src_n = n;
        src_gen++;
    endtask

    task automatic start_load(input logic [31:0] base, input int len);
        @(negedge clk);
        bus.i_start    = 1'b1;
        bus.i_base_adr = base;
        bus.i_len      = LEN_W'(len);
        @(negedge clk);
        bus.i_start    = 1'b0;
    endtask

    task automatic wait_done(input string name, input int budget);
        bit seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge clk);
            if (bus.o_done) seen = 1'b1;
        end
        check({name, "_done_seen"}, 64'(seen), 64'd1);
        if (seen) check({name, "_idle_at_done"}, {bus.o_debug_mode, bus.o_busy}, 64'd0);
        repeat (2) @(negedge clk);
    endtask

    int done0, dbg0, stb0, wr0, acc0;

    initial begin
        bus.i_start    = 1'b0;
        bus.i_base_adr = '0;
        bus.i_len      = '0;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_flags", {bus.o_busy, bus.o_done, bus.o_err, bus.o_debug_mode,
                            bus.o_wb_stb, bus.o_wb_we, bus.o_byte_ready}, 64'd0);
        check("rst_adr_dat_sel", {bus.o_wb_adr, bus.o_wb_sel}, 64'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Full words, ack one cycle late, with an ignored start mid-load
        ack_lat = 1;
        set_seq(8'h00, 8);
        done0 = done_cnt; wr0 = wr_n;
        start_load(32'h0, 8);
        check("t1_busy_debug_stb", {bus.o_busy, bus.o_debug_mode, bus.o_wb_stb}, 64'b110);
        repeat (5) @(negedge clk);
        bus.i_start = 1'b1; bus.i_base_adr = 32'h999; bus.i_len = 16'd3;
        @(negedge clk);
        bus.i_start = 1'b0;
        wait_done("t1", 200);
        check("t1_nwrites", 64'(wr_n - wr0), 64'd2);
        check("t1_w0", {wr_adr[wr0], wr_dat[wr0]}, {32'h0, 32'h03020100});
        check("t1_w1", {wr_adr[wr0+1], wr_dat[wr0+1]}, {32'h4, 32'h07060504});
        check("t1_done_once", 64'(done_cnt - done0), 64'd1);
        check("t1_err", 64'(bus.o_err), 64'd0);

        // Partial final word zero-padded; ack on the last cycle before timeout
        ack_lat = 3;
        src_mem[0] = 8'hAA; src_mem[1] = 8'hBB; src_mem[2] = 8'hCC;
        src_mem[3] = 8'hDD; src_mem[4] = 8'hEE;
        src_n = 5; src_gen++;
        wr0 = wr_n;
        start_load(32'h100, 5);
        wait_done("t2", 200);
        check("t2_nwrites", 64'(wr_n - wr0), 64'd2);
        check("t2_w0", {wr_adr[wr0], wr_dat[wr0]}, {32'h100, 32'hDDCCBBAA});
        check("t2_w1", {wr_adr[wr0+1], wr_dat[wr0+1]}, {32'h104, 32'h000000EE});
        check("t2_err", 64'(bus.o_err), 64'd0);

        // Empty load: settle only, no bus traffic
        ack_lat = 0;
        src_n = 0; src_gen++;
        done0 = done_cnt; dbg0 = debug_cnt; stb0 = stb_cnt;
        start_load(32'h200, 0);
        wait_done("t3", 100);
        check("t3_debug_cycles", 64'(debug_cnt - dbg0), 64'(2*SETTLE + 1));
        check("t3_stb_cycles", 64'(stb_cnt - stb0), 64'd0);
        check("t3_done_once", 64'(done_cnt - done0), 64'd1);
        check("t3_err", 64'(bus.o_err), 64'd0);

        // Ack never arrives: timeout, remaining bytes left unconsumed
        ack_en = 1'b0;
        set_seq(8'h50, 8);
        stb0 = stb_cnt; acc0 = acc_cnt; done0 = done_cnt;
        start_load(32'h300, 8);
        wait_done("t4", 200);
        check("t4_stb_cycles", 64'(stb_cnt - stb0), 64'(TIMEOUT));
        check("t4_err", 64'(bus.o_err), 64'd1);
        check("t4_bytes_taken", 64'(acc_cnt - acc0), 64'd4);
        check("t4_done_once", 64'(done_cnt - done0), 64'd1);
        ack_en = 1'b1;

        // Next accepted start clears the sticky error
        src_n = 0; src_gen++;
        start_load(32'h0, 0);
        check("t4_err_cleared", {bus.o_err, bus.o_busy}, 64'b01);
        wait_done("t4b", 100);

        // Asynchronous reset while a write is outstanding
        ack_lat = 2;
        set_seq(8'h60, 8);
        start_load(32'h400, 8);
        begin
            bit stb_seen = 1'b0;
            for (int i = 0; i < 50 && !stb_seen; i++) begin
                @(negedge clk);
                if (bus.o_wb_stb) stb_seen = 1'b1;
            end
            check("t5_stb_reached", 64'(stb_seen), 64'd1);
        end
        #1 rst = 1'b1;
        #1 check("t5_async_drop", {bus.o_wb_stb, bus.o_debug_mode, bus.o_busy, bus.o_byte_ready}, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        ack_lat = 0;
        set_seq(8'h10, 8);
        wr0 = wr_n;
        start_load(32'h40, 8);
        wait_done("t5", 200);
        check("t5_w0", {wr_adr[wr0], wr_dat[wr0]}, {32'h40, 32'h13121110});
        check("t5_w1", {wr_adr[wr0+1], wr_dat[wr0+1]}, {32'h44, 32'h17161514});
        check("t5_err", 64'(bus.o_err), 64'd0);

`ifdef SUBSERVIENT_DBG_LOADER_READBACK_EN
        // Readback sees a flipped bit in word 1; load still writes every word
        corrupt_en = 1'b1; corrupt_adr = 32'h204;
        set_seq(8'h20, 12);
        wr0 = wr_n;
        start_load(32'h200, 12);
        wait_done("t6", 300);
        check("t6_nwrites", 64'(wr_n - wr0), 64'd3);
        check("t6_w2", {wr_adr[wr0+2], wr_dat[wr0+2]}, {32'h208, 32'h2B2A2928});
        check("t6_err", 64'(bus.o_err), 64'd1);
        corrupt_en = 1'b0;
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
